// File: rtl/mc_pkg.sv
// mc_pkg: shared frame layout, scheduler states and array select codes for the
// memory-controller front-end scheduler.
package mc_pkg;
  // Flag positions counted down from the frame MSB, so they hold for any frame width.
  localparam int FRAME_SOF_BIT = 0;
  localparam int FRAME_EOF_BIT = 1;
  localparam int FRAME_WR_BIT  = 2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_RF
  } state_t;
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_RD   = 2'd2,
    SEL_RF   = 2'd3
  } sel_t;
  function automatic sel_t sel_of(state_t s);
    return (s == ST_WR || s == ST_WR_WAIT) ? SEL_WR :
           (s == ST_RD || s == ST_RD_WAIT) ? SEL_RD :
           (s == ST_RF) ? SEL_RF : SEL_IDLE;
  endfunction
endpackage

// File: rtl/mc_frame_sched_if.sv
// mc_frame_sched_if: valid/ready frame stream between the frame source, the
// scheduler and the array engines.
interface mc_frame_sched_if #(
  parameter int W = 87
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mc_rf_timer.sv
// mc_rf_timer: refresh interval counter; raises rf_pending on expiry and flags
// rf_miss when an expiry lands on a refresh that is still pending.
module mc_rf_timer #(
  parameter int RF_CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [RF_CNT_WIDTH-1:0] period,
  input  logic                    rf_take,
  output logic                    rf_pending,
  output logic                    rf_miss
);
  logic [RF_CNT_WIDTH-1:0] timer_q, timer_d;
  logic                    pending_q, pending_d;
  logic                    miss_q, miss_d;
  logic                    run, expire;
  always_comb begin
    run       = en && (period != '0);
    // >= so a period shrunk below the current count wraps on the next cycle
    expire    = run && (timer_q >= period - 1'b1);
    timer_d   = (!run || expire) ? '0 : timer_q + 1'b1;
    pending_d = !run ? 1'b0 : expire ? 1'b1 : rf_take ? 1'b0 : pending_q;
    miss_d    = expire && pending_q && !rf_take;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
    end
  assign rf_pending = pending_q;
  assign rf_miss    = miss_q;
endmodule

// File: rtl/mc_frame_sched.sv
// mc_frame_sched: steers whole sof..eof bursts to the write or read engine and
// slots refresh requests in between bursts.
module mc_frame_sched
  import mc_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int RF_CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mc_en,
  input  logic [RF_CNT_WIDTH-1:0] mc_rf_period_cfg,
  mc_frame_sched_if.slave         axi_frame,
  mc_frame_sched_if.master        axi_frame_wr,
  mc_frame_sched_if.master        axi_frame_rd,
  input  logic                    wr_done,
  input  logic                    rd_done,
  output logic                    rf_start,
  input  logic                    rf_done,
  output logic [1:0]              array_mux_sel,
  output logic                    frame_err,
  output logic                    rf_miss
);
  state_t state_q, state_d;
  sel_t   sel_q, sel_d;
  logic   rf_start_q, rf_start_d;
  logic   frame_err_q, frame_err_d;
  logic   rf_take, rf_pending;
  logic   sof, eof, wr, in_wr, in_rd, drop;
  assign sof = axi_frame.data[AXI_FRAME_WIDTH-1-FRAME_SOF_BIT];
  assign eof = axi_frame.data[AXI_FRAME_WIDTH-1-FRAME_EOF_BIT];
  assign wr  = axi_frame.data[AXI_FRAME_WIDTH-1-FRAME_WR_BIT];
  mc_rf_timer #(.RF_CNT_WIDTH(RF_CNT_WIDTH)) u_rf_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (mc_en),
    .period     (mc_rf_period_cfg),
    .rf_take    (rf_take),
    .rf_pending (rf_pending),
    .rf_miss    (rf_miss)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_IDLE;
      rf_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rf_start_q  <= rf_start_d;
      frame_err_q <= frame_err_d;
    end
  // Refresh is checked first in IDLE, so a pending refresh beats a waiting sof.
  always_comb begin
    state_d = state_q;
    rf_take = 1'b0;
    case (state_q)
      ST_IDLE:
        if (mc_en && rf_pending) begin
          state_d = ST_RF;
          rf_take = 1'b1;
        end else if (mc_en && axi_frame.valid && sof) state_d = wr ? ST_WR : ST_RD;
      ST_WR:      if (axi_frame.valid && axi_frame_wr.ready && eof) state_d = ST_WR_WAIT;
      ST_RD:      if (axi_frame.valid && axi_frame_rd.ready && eof) state_d = ST_RD_WAIT;
      ST_WR_WAIT: if (wr_done) state_d = ST_IDLE;
      ST_RD_WAIT: if (rd_done) state_d = ST_IDLE;
      ST_RF:      if (rf_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end
  // Stray non-sof frames are swallowed in IDLE; rst_n gating keeps ready low during reset.
  always_comb begin
    in_wr       = state_q == ST_WR;
    in_rd       = state_q == ST_RD;
    drop        = rst_n && state_q == ST_IDLE && mc_en && !rf_pending && axi_frame.valid && !sof;
    sel_d       = sel_of(state_d);
    rf_start_d  = rf_take;
    frame_err_d = drop;
  end
  assign axi_frame_wr.data  = in_wr ? axi_frame.data : '0;
  assign axi_frame_wr.valid = in_wr && axi_frame.valid;
  assign axi_frame_rd.data  = in_rd ? axi_frame.data : '0;
  assign axi_frame_rd.valid = in_rd && axi_frame.valid;
  assign axi_frame.ready    = in_wr ? axi_frame_wr.ready : in_rd ? axi_frame_rd.ready : drop;
  assign array_mux_sel      = sel_q;
  assign rf_start           = rf_start_q;
  assign frame_err          = frame_err_q;
endmodule
